// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared FSM state type, depth helper and default register file geometry
package reg_file_pkg;
    typedef enum logic {CLEAR, READY} rf_state_t;
    localparam int W_DEF  = 8;
    localparam int PW_DEF = 4;
    localparam int NR_DEF = 2;
    function automatic int rf_depth(input int pw);
        return 1 << pw;
    endfunction
    localparam int DEPTH_DEF = rf_depth(PW_DEF);
endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: decode/writeback-facing bus of the multi-port register file
interface reg_file_mp_if #(
    parameter int W  = reg_file_pkg::W_DEF,
    parameter int PW = reg_file_pkg::PW_DEF,
    parameter int NR = reg_file_pkg::NR_DEF
);
    logic              wr_en;
    logic [PW-1:0]     wr_addr;
    logic [W-1:0]      dat_in;
    logic [NR*PW-1:0]  rd_addr;
    logic [NR*W-1:0]   rd_data;
    logic              clr_req;
    logic              busy;
    logic [(1<<PW)-1:0] valid;
    logic              wr_drop;

    modport master (
        output wr_en, wr_addr, dat_in, rd_addr, clr_req,
        input  rd_data, busy, valid, wr_drop
    );
    modport slave (
        input  wr_en, wr_addr, dat_in, rd_addr, clr_req,
        output rd_data, busy, valid, wr_drop
    );
endinterface

// File: rtl/reg_file_mp_clear_ctrl.sv
// rf_clear_ctrl: CLEAR/READY FSM and sweep counter that zeroes every entry after reset or clr_req
module rf_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [PW-1:0] clr_addr
);
    localparam logic [PW:0] LAST = (PW+1)'(rf_depth(PW) - 1);

    rf_state_t   state, state_nxt;
    logic [PW:0] cnt, cnt_nxt;

    // state and sweep counter registers; reset restarts the sweep from entry 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // a clear request restarts the sweep from any state; the last entry hands over to READY
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (clr_req) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
        end else if (state == CLEAR) begin
            state_nxt = (cnt == LAST) ? READY : CLEAR;
            cnt_nxt   = (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy && rst_n;
    assign clr_addr = cnt[PW-1:0];
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised NR-read/1-write register file with clear sweep and written-valid bitmap
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int PW = PW_DEF,
    parameter int NR = NR_DEF
) (
    input logic         clk,
    input logic         rst_n,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = rf_depth(PW);

    logic [W-1:0]     core [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic             wr_drop_q;
    logic             busy;
    logic             clr_we;
    logic [PW-1:0]    clr_addr;
    logic             wr_fire;

    rf_clear_ctrl #(.PW(PW)) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (bus.clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // a write lands only in READY and loses to a simultaneous clear request
    assign wr_fire = rst_n && !busy && bus.wr_en && !bus.clr_req;

    // storage: the sweep zeroes one entry per cycle, otherwise the writeback port writes
    always_ff @(posedge clk) begin
        if (clr_we)
            core[clr_addr] <= '0;
        else if (wr_fire)
            core[bus.wr_addr] <= bus.dat_in;
    end

    // valid bitmap tracks writes since the last clear; wr_drop latches writes lost to the sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            if (bus.clr_req)
                valid_q <= '0;
            else if (wr_fire)
                valid_q[bus.wr_addr] <= 1'b1;
            if (busy && bus.wr_en)
                wr_drop_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [PW-1:0] ra;
        logic [W-1:0]  rd;
        assign ra = bus.rd_addr[i*PW +: PW];
`ifdef REG_FILE_BYPASS_EN
        assign rd = (bus.wr_en && ra == bus.wr_addr) ? bus.dat_in : core[ra];
`else
        assign rd = core[ra];
`endif
        assign bus.rd_data[i*W +: W] = busy ? '0 : rd;
    end

    assign bus.busy    = busy;
    assign bus.valid   = valid_q;
    assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp (W=8, PW=4, NR=2)
module tb_reg_file_mp;
    logic clk = 0;
    logic rst_n;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    reg_file_mp_if #(.W(8), .PW(4), .NR(2)) bus ();

    reg_file_mp #(.W(8), .PW(4), .NR(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reads every address on both ports; returns OR of all read data
    task automatic read_all(output logic [15:0] acc);
        acc = '0;
        for (int k = 0; k < 16; k++) begin
            bus.rd_addr = {4'(k), 4'(15 - k)};
            #1;
            acc |= bus.rd_data;
        end
    endtask

    // runs n sweep edges; flags busy low before the last edge or read data nonzero while busy
    task automatic sweep(input int n, input int wr_at, output int bad_busy, output int bad_rd);
        bad_busy = 0;
        bad_rd = 0;
        for (int j = 1; j <= n; j++) begin
            if (j == wr_at) begin
                bus.wr_en = 1; bus.wr_addr = 4'd2; bus.dat_in = 8'h77;
            end else begin
                bus.wr_en = 0;
            end
            tick();
            if (j < n && bus.busy !== 1'b1) bad_busy++;
            if (bus.busy && bus.rd_data !== 16'h0) bad_rd++;
        end
        bus.wr_en = 0;
    endtask

    logic [15:0] acc;
    int bb, br;

    initial begin
        rst_n = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.dat_in = 0; bus.rd_addr = 0; bus.clr_req = 0;
        tick();
        chk("busy_in_reset", bus.busy, 1);
        tick();
        rst_n = 1;
        sweep(16, 0, bb, br);
        chk("reset_sweep_busy", bb, 0);
        chk("reset_sweep_end", bus.busy, 0);
        read_all(acc);
        chk("reset_all_zero", acc, 0);
        chk("reset_valid", bus.valid, 16'h0000);
        chk("reset_wr_drop", bus.wr_drop, 0);

        bus.wr_en = 1; bus.wr_addr = 4'd3; bus.dat_in = 8'hA5;
        tick();
        bus.wr_addr = 4'd12; bus.dat_in = 8'h5A;
        tick();
        bus.wr_en = 0; bus.rd_addr = {4'd12, 4'd3};
        #1;
        chk("wr_rd_data", bus.rd_data, 16'h5AA5);
        chk("wr_valid", bus.valid, 16'h1008);

        bus.wr_en = 1; bus.wr_addr = 4'd5; bus.dat_in = 8'h11;
        tick();
        bus.dat_in = 8'h3C; bus.rd_addr = {4'd5, 4'd5};
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("rdw_same_cycle", bus.rd_data, 16'h3C3C);
`else
        chk("rdw_same_cycle", bus.rd_data, 16'h1111);
`endif
        tick();
        bus.wr_en = 0;
        #1;
        chk("rdw_next_cycle", bus.rd_data, 16'h3C3C);
        chk("rdw_valid", bus.valid, 16'h1028);

        bus.clr_req = 1; bus.wr_en = 1; bus.wr_addr = 4'd7; bus.dat_in = 8'h99;
        bus.rd_addr = {4'd12, 4'd3};
        tick();
        bus.clr_req = 0; bus.wr_en = 0;
        chk("clr_busy", bus.busy, 1);
        chk("clr_no_drop_yet", bus.wr_drop, 0);
        chk("clr_valid_now", bus.valid, 16'h0000);
        sweep(16, 4, bb, br);
        chk("clr_sweep_busy", bb, 0);
        chk("clr_sweep_rd_zero", br, 0);
        chk("clr_sweep_end", bus.busy, 0);
        chk("clr_wr_drop", bus.wr_drop, 1);
        read_all(acc);
        chk("clr_all_zero", acc, 0);
        chk("clr_valid", bus.valid, 16'h0000);

        bus.clr_req = 1;
        tick();
        bus.clr_req = 0;
        sweep(8, 0, bb, br);
        rst_n = 0;
        tick();
        chk("mid_reset_busy", bus.busy, 1);
        chk("mid_reset_wr_drop", bus.wr_drop, 0);
        rst_n = 1;
        sweep(16, 0, bb, br);
        chk("mid_reset_sweep_busy", bb, 0);
        chk("mid_reset_sweep_end", bus.busy, 0);
        chk("mid_reset_wr_drop_end", bus.wr_drop, 0);

        bus.clr_req = 1;
        tick();
        bus.clr_req = 0;
        sweep(9, 0, bb, br);
        chk("rereq_pre_busy", bus.busy, 1);
        bus.clr_req = 1;
        tick();
        bus.clr_req = 0;
        sweep(16, 0, bb, br);
        chk("rereq_sweep_busy", bb, 0);
        chk("rereq_sweep_end", bus.busy, 0);

        bus.wr_en = 1; bus.wr_addr = 4'd9; bus.dat_in = 8'h42;
        tick();
        bus.wr_en = 0; bus.rd_addr = {4'd0, 4'd9};
        #1;
        chk("post_write_data", bus.rd_data, 16'h0042);
        chk("post_write_valid", bus.valid, 16'h0200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor of the 8-bit, 16-deep, 2-read/1-write core register file.
- Configurable data width, depth and read-port count.
- A hardware clear sweep runs after reset and on request; a per-entry written-valid bitmap is kept.
- Sits in the datapath between the decode stage (read addresses) and the writeback stage (write port).

Parameters:
W, 8, data width in bits
PW, 4, address pointer width; depth = 2**PW
NR, 2, number of combinational read ports (1..4)

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
wr_en  in  1  write enable
wr_addr  in  PW  write address pointer
dat_in  in  W  write data
rd_addr  in  NR*PW  packed read addresses; port i uses bits [i*PW +: PW]
rd_data  out  NR*W  packed read data; port i uses bits [i*W +: W]
clr_req  in  1  single-cycle pulse; starts a full clear sweep
busy  out  1  high while the clear sweep runs
valid  out  2**PW  bit k = entry k written since the last clear
wr_drop  out  1  sticky; set when a write is ignored during busy

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM goes to CLEAR; sweep counter = 0; valid = 0; wr_drop = 0.
  - busy = 1 from the first posedge with rst_n low.
  - Array contents are not touched by reset itself; the sweep zeroes them.
- FSM states: CLEAR and READY.
  - CLEAR: each cycle writes 0 to core[cnt], then cnt++. When cnt == 2**PW-1 is written, the next state is READY and busy drops.
  - Sweep length is exactly 2**PW cycles (16 for PW=4).
  - READY: normal operation. clr_req=1 moves to CLEAR with cnt=0 and valid=0, effective at that edge.
  - clr_req while already in CLEAR restarts the sweep at cnt=0.
  - Reset mid-sweep also restarts the sweep at cnt=0.
- Reads:
  - Combinational: rd_data[i] = core[rd_addr[i]].
  - While busy, rd_data is forced to all-zero on every port.
- Writes:
  - Sequential. In READY with wr_en=1: core[wr_addr] <= dat_in and valid[wr_addr] <= 1 at the posedge.
  - In CLEAR, wr_en=1 is ignored and sets wr_drop. wr_drop clears only on reset.
- Simultaneous clr_req and wr_en in READY: the clear wins and the write is dropped. wr_drop is not set, because the FSM was not yet busy.
- Read-during-write to the same address, without the optional feature: a read returns the old value in that cycle and the new value from the next cycle.
- cnt is PW+1 bits wide so the terminal compare cannot wrap falsely. No arithmetic on data.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: when READY, wr_en=1 and rd_addr[i]==wr_addr, rd_data[i] = dat_in combinationally (write-to-read forwarding, all ports independently).
- Undefined: no forwarding; old value is returned in the write cycle.
- Forwarding never applies while busy; zero-forcing has priority.

Decomposition:
- Package reg_file_pkg holds:
  - typedef enum logic {CLEAR, READY} rf_state_t
  - localparam helpers DEPTH(PW)
  - default W/PW/NR constants shared with decode and writeback.
- One natural sub-module, rf_clear_ctrl: owns the FSM, sweep counter, busy and clear-write strobe/address.
- Array, read muxes and bypass stay in reg_file_mp.

Test Plan:
- Reset sweep:
  - Stimulus: hold rst_n=0 for 2 cycles, then release; W=8, PW=4, NR=2.
  - Response: busy=1 for exactly 16 cycles after release, then 0. Reading all 16 addresses gives 0x00; valid=16'h0000.
- Write/read:
  - Stimulus: in READY, write 0xA5 to addr 3 and 0x5A to addr 12.
  - Response: next cycle, rd_addr={12,3} gives rd_data={0x5A,0xA5}; valid=16'h1008.
- Read-during-write:
  - Stimulus: addr 5 holds 0x11; write 0x3C to addr 5 while reading addr 5.
  - Response: same cycle returns 0x3C with REG_FILE_BYPASS_EN, 0x11 without. The following cycle returns 0x3C in both builds.
- Clear request:
  - Stimulus: pulse clr_req with wr_en=1 in the same cycle, then write 0x77 at cycle 4 of the sweep.
  - Response: busy for 16 cycles and rd_data=0 throughout. wr_drop=1 (from the cycle-4 write only); all entries read 0x00 afterwards; valid=0.
- Reset mid-sweep:
  - Stimulus: assert rst_n=0 at sweep cycle 9.
  - Response: sweep restarts; busy stays high for a full 16 cycles after release; wr_drop=0.
- Re-request during sweep:
  - Stimulus: clr_req at sweep cycle 10.
  - Response: busy remains high for 16 further cycles, counted from that edge.
